// File: rtl/eae_divider_pkg.sv
// Shared EAE divider types: word widths, working registers and divider FSM states.
package eae_divider_pkg;

  localparam int unsigned W     = 12;
  localparam int unsigned CNT_W = $clog2(W + 1);

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] dword_t;
  typedef logic [W:0]     rem_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CHECK,
    DIV_DIVIDE,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/eae_divider.sv
// EAE DVI restoring divider: {AC,MQ} / MB, one quotient bit per clock.
// The result is a quotient to MQ, a remainder to AC, and link_out (divide overflow) to L.
module eae_divider
  import eae_divider_pkg::*;
(
  input  logic           clock,
  input  logic           resetN,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           link_out,
  output logic           finished,
  output logic           busy
);

  div_state_t       state, state_n;
  word_t            rem_r, rem_n;   // partial remainder R (its carry bit lives only in shifted)
  word_t            quo_r, quo_n;   // partial quotient Q, shifted left each iteration
  word_t            dvs_r, dvs_n;   // captured divisor
  logic [CNT_W-1:0] cnt_r, cnt_n;
  word_t            quotient_n, remainder_n;
  logic             link_n, finished_n, busy_n;

  rem_t             shifted;
  logic             fits;

  // Next-state, shift/compare/subtract, and next-value logic for every register.
  always_comb begin
    state_n     = state;
    rem_n       = rem_r;
    quo_n       = quo_r;
    dvs_n       = dvs_r;
    cnt_n       = cnt_r;
    quotient_n  = quotient;
    remainder_n = remainder;
    link_n      = link_out;
    finished_n  = 1'b0;
    busy_n      = busy;

    // After a restoring step, R < divisor, so R fits in W bits. The shifted value needs W+1 bits.
    shifted = {rem_r, quo_r[W-1]};
    fits    = (shifted >= {1'b0, dvs_r});

    case (state)
      DIV_IDLE: begin
        if (start) begin
          rem_n   = dividend[2*W-1:W];
          quo_n   = dividend[W-1:0];
          dvs_n   = divisor;
          busy_n  = 1'b1;
          state_n = DIV_CHECK;
        end
      end
      DIV_CHECK: begin
        // AC >= MB (including MB == 0) cannot fit a W-bit quotient: leave AC/MQ, set L.
        if (rem_r >= dvs_r) begin
          quotient_n  = quo_r;
          remainder_n = rem_r;
          link_n      = 1'b1;
          finished_n  = 1'b1;
          state_n     = DIV_DONE;
        end else begin
          cnt_n   = CNT_W'(W);
          state_n = DIV_DIVIDE;
        end
      end
      DIV_DIVIDE: begin
        rem_n = fits ? W'(shifted - {1'b0, dvs_r}) : shifted[W-1:0];
        quo_n = {quo_r[W-2:0], fits};
        cnt_n = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          quotient_n  = {quo_r[W-2:0], fits};
          remainder_n = fits ? W'(shifted - {1'b0, dvs_r}) : shifted[W-1:0];
          link_n      = 1'b0;
          finished_n  = 1'b1;
          state_n     = DIV_DONE;
        end
      end
      DIV_DONE: begin
        busy_n  = 1'b0;
        state_n = DIV_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = DIV_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Reset aborts any divide in progress.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= DIV_IDLE;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      cnt_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      link_out  <= 1'b0;
      finished  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      rem_r     <= rem_n;
      quo_r     <= quo_n;
      dvs_r     <= dvs_n;
      cnt_r     <= cnt_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      link_out  <= link_n;
      finished  <= finished_n;
      busy      <= busy_n;
    end
  end

endmodule
